demux3_reg: RTL and testbench

//  Registered 1-to-3 demultiplexer with valid/ready handshakes: the distributing

---
 rtl/demux3_reg.sv | 139 +++++++++++++
 tb/tb_demux3_reg.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux3_reg.sv
// Registered 1-to-3 demultiplexer with valid/ready handshakes.
// One word per cycle enters on the input and is routed by select code to one
// of three lanes. Each lane owns a one-entry holding register, so a stalled
// consumer only blocks words aimed at its own lane. Select code 3 is illegal:
// such words are consumed, dropped, flagged (sticky) and counted (saturating).

module demux3_reg #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   RESET_DATA = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out3_data,
    output logic             out3_valid,
    input  logic             out3_ready,
    output logic             err_illegal,
    output logic [7:0]       drop_count
);

    // Saturating increment for the 8-bit drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    logic [WIDTH-1:0] lane_data_r [3];
    logic [2:0]       lane_valid_r;
    logic             err_illegal_r;
    logic [7:0]       drop_count_r;

    logic [2:0]       lane_ready_s;
    logic [2:0]       lane_open_s;
    logic [2:0]       lane_sel_s;
    logic             illegal_sel_s;
    logic             in_ready_s;
    logic [2:0]       lane_wr_s;
    logic [2:0]       lane_drain_s;
    logic             drop_s;

    assign lane_ready_s = {out3_ready, out2_ready, out1_ready};

    // A lane can take a new word when it is empty or is draining this cycle.
    assign lane_open_s  = ~lane_valid_r | lane_ready_s;
    assign lane_drain_s = lane_valid_r & lane_ready_s;

    // Decode select into a one-hot lane request; select is ignored without in_valid.
    always_comb begin
        lane_sel_s    = 3'b000;
        illegal_sel_s = 1'b0;
        if (in_valid) begin
            case (select)
                2'd0:    lane_sel_s    = 3'b001;
                2'd1:    lane_sel_s    = 3'b010;
                2'd2:    lane_sel_s    = 3'b100;
                2'd3:    illegal_sel_s = 1'b1;
                default: lane_sel_s    = 3'b000;
            endcase
        end else begin
            lane_sel_s    = 3'b000;
            illegal_sel_s = 1'b0;
        end
    end

    // Input readiness follows the selected lane only; illegal words are always taken.
    always_comb begin
        in_ready_s = 1'b1;
        case (select)
            2'd0:    in_ready_s = lane_open_s[0];
            2'd1:    in_ready_s = lane_open_s[1];
            2'd2:    in_ready_s = lane_open_s[2];
            2'd3:    in_ready_s = 1'b1;
            default: in_ready_s = 1'b1;
        endcase
    end

    assign in_ready  = in_ready_s;
    assign lane_wr_s = lane_sel_s & lane_open_s;
    assign drop_s    = illegal_sel_s;

    // Lane holding registers: a new word wins over a drain on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                lane_data_r[k]  <= RESET_DATA;
                lane_valid_r[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (lane_wr_s[k]) begin
                    lane_data_r[k]  <= in_data;
                    lane_valid_r[k] <= 1'b1;
                end else if (lane_drain_s[k]) begin
                    lane_valid_r[k] <= 1'b0;
                end else begin
                    lane_valid_r[k] <= lane_valid_r[k];
                end
            end
        end
    end

    // Sticky illegal-select flag and saturating count of dropped words.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_illegal_r <= 1'b0;
            drop_count_r  <= 8'd0;
        end else if (drop_s) begin
            err_illegal_r <= 1'b1;
            drop_count_r  <= sat_inc8(drop_count_r);
        end else begin
            err_illegal_r <= err_illegal_r;
            drop_count_r  <= drop_count_r;
        end
    end

    assign out1_data   = lane_data_r[0];
    assign out2_data   = lane_data_r[1];
    assign out3_data   = lane_data_r[2];
    assign out1_valid  = lane_valid_r[0];
    assign out2_valid  = lane_valid_r[1];
    assign out3_valid  = lane_valid_r[2];
    assign err_illegal = err_illegal_r;
    assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_demux3_reg.sv
// Self-checking bench for demux3_reg: per-lane scoreboard queues plus
// directed scenario tasks and a random traffic phase.

module tb_demux3_reg;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [2:0]  ordy;
    logic [31:0] out1_data, out2_data, out3_data;
    logic        out1_valid, out2_valid, out3_valid;
    logic        err_illegal;
    logic [7:0]  drop_count;

    logic [31:0] od [3];
    logic [2:0]  ov;

    int compared;
    int mismatched;
    bit sb_on;

    // Reference model state
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    logic [31:0] mdata [3];
    logic [2:0]  mv;
    logic        merr;
    logic [7:0]  mdrop;

    demux3_reg #(.WIDTH(32), .RESET_DATA(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .select     (sel),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (ordy[0]),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (ordy[1]),
        .out3_data  (out3_data),
        .out3_valid (out3_valid),
        .out3_ready (ordy[2]),
        .err_illegal(err_illegal),
        .drop_count (drop_count)
    );

    assign od[0] = out1_data;
    assign od[1] = out2_data;
    assign od[2] = out3_data;
    assign ov    = {out3_valid, out2_valid, out1_valid};

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock cycle: check outputs against the model, update the scoreboard, cross the edge.
    task automatic step();
        logic        exp_rdy;
        logic [31:0] got;
        bit          empty;
        #3;
        case (sel)
            2'd0:    exp_rdy = !mv[0] || ordy[0];
            2'd1:    exp_rdy = !mv[1] || ordy[1];
            2'd2:    exp_rdy = !mv[2] || ordy[2];
            default: exp_rdy = 1'b1;
        endcase
        if (sb_on) begin
            compared++;
            if (in_ready !== exp_rdy) begin
                mismatched++;
                $display("FAIL in_ready: got %b expected %b (sel=%0d)", in_ready, exp_rdy, sel);
            end
            for (int k = 0; k < 3; k++) begin
                compared++;
                if (ov[k] !== mv[k] || od[k] !== mdata[k]) begin
                    mismatched++;
                    $display("FAIL lane%0d state: got v=%b d=%h expected v=%b d=%h",
                             k + 1, ov[k], od[k], mv[k], mdata[k]);
                end
            end
            compared++;
            if (err_illegal !== merr || drop_count !== mdrop) begin
                mismatched++;
                $display("FAIL err/drop: got %b/%0d expected %b/%0d", err_illegal, drop_count, merr, mdrop);
            end
        end
        if (reset) begin
            q0.delete(); q1.delete(); q2.delete();
            for (int k = 0; k < 3; k++) mdata[k] = 32'h0000_0000;
            mv    = 3'b000;
            merr  = 1'b0;
            mdrop = 8'd0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (mv[k] && ordy[k]) begin
                    got   = 32'h0000_0000;
                    empty = 1'b0;
                    case (k)
                        0:       if (q0.size() == 0) empty = 1'b1; else got = q0.pop_front();
                        1:       if (q1.size() == 0) empty = 1'b1; else got = q1.pop_front();
                        default: if (q2.size() == 0) empty = 1'b1; else got = q2.pop_front();
                    endcase
                    if (sb_on) begin
                        compared++;
                        if (empty || od[k] !== got) begin
                            mismatched++;
                            $display("FAIL lane%0d delivery: got %h expected %h (queue empty=%b)",
                                     k + 1, od[k], got, empty);
                        end
                    end
                    mv[k] = 1'b0;
                end
            end
            if (in_valid && exp_rdy) begin
                case (sel)
                    2'd0: begin q0.push_back(in_data); mdata[0] = in_data; mv[0] = 1'b1; end
                    2'd1: begin q1.push_back(in_data); mdata[1] = in_data; mv[1] = 1'b1; end
                    2'd2: begin q2.push_back(in_data); mdata[2] = in_data; mv[2] = 1'b1; end
                    default: begin
                        merr = 1'b1;
                        if (mdrop != 8'hFF) mdrop = mdrop + 8'd1;
                    end
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        sel      = 2'd0;
        in_data  = 32'hDEAD_BEEF;
        ordy     = 3'b000;
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        sb_on    = 1'b1;
        compared++;
        if (ov !== 3'b000 || out1_data !== 32'h0 || out2_data !== 32'h0 || out3_data !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_lanes: got v=%b d=%h/%h/%h expected v=000 d=0",
                     ov, out1_data, out2_data, out3_data);
        end
        compared++;
        if (err_illegal !== 1'b0 || drop_count !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_err: got %b/%0d expected 0/0", err_illegal, drop_count);
        end
    endtask

    task automatic test_single_route();
        ordy     = 3'b010;
        in_valid = 1'b1;
        sel      = 2'd1;
        in_data  = 32'h0000_1234;
        step();
        in_valid = 1'b0;
        compared++;
        if (out2_valid !== 1'b1 || out2_data !== 32'h0000_1234 || out1_valid !== 1'b0 || out3_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL single_route: got v=%b d2=%h expected v=010 d2=00001234", ov, out2_data);
        end
        step();
        compared++;
        if (out2_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL single_route_drain: got out2_valid=%b expected 0", out2_valid);
        end
    endtask

    task automatic test_full_replace();
        ordy     = 3'b000;
        in_valid = 1'b1;
        sel      = 2'd2;
        in_data  = 32'hAAAA_0001;
        step();
        in_data = 32'hBBBB_0002;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL full_stall_ready: got %b expected 0", in_ready);
        end
        step();
        compared++;
        if (out3_valid !== 1'b1 || out3_data !== 32'hAAAA_0001) begin
            mismatched++;
            $display("FAIL full_hold: got v=%b d=%h expected v=1 d=aaaa0001", out3_valid, out3_data);
        end
        ordy[2] = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL full_drain_ready: got %b expected 1", in_ready);
        end
        step();
        compared++;
        if (out3_valid !== 1'b1 || out3_data !== 32'hBBBB_0002) begin
            mismatched++;
            $display("FAIL full_replace: got v=%b d=%h expected v=1 d=bbbb0002", out3_valid, out3_data);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        ordy     = 3'b000;
        in_valid = 1'b1;
        sel      = 2'd0;
        in_data  = 32'hC0C0_C0C0;
        step();
        ordy = 3'b110;
        for (int i = 0; i < 20; i++) begin
            sel     = (i % 2 == 0) ? 2'd1 : 2'd2;
            in_data = $urandom;
            #1;
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b_ready: got %b expected 1 at word %0d", in_ready, i);
            end
            step();
            compared++;
            if (out1_valid !== 1'b1 || out1_data !== 32'hC0C0_C0C0) begin
                mismatched++;
                $display("FAIL b2b_lane1_hold: got v=%b d=%h expected v=1 d=c0c0c0c0", out1_valid, out1_data);
            end
        end
        in_valid = 1'b0;
        ordy     = 3'b111;
        step();
        step();
    endtask

    task automatic test_illegal();
        ordy     = 3'b111;
        in_valid = 1'b1;
        sel      = 2'd3;
        for (int i = 0; i < 300; i++) begin
            in_data = $urandom;
            #1;
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL illegal_ready: got %b expected 1 at word %0d", in_ready, i);
            end
            step();
            if (i == 0) begin
                compared++;
                if (err_illegal !== 1'b1 || drop_count !== 8'd1) begin
                    mismatched++;
                    $display("FAIL illegal_first: got %b/%0d expected 1/1", err_illegal, drop_count);
                end
            end
        end
        in_valid = 1'b0;
        compared++;
        if (err_illegal !== 1'b1 || drop_count !== 8'd255 || ov !== 3'b000) begin
            mismatched++;
            $display("FAIL illegal_saturate: got err=%b drop=%0d v=%b expected 1/255/000",
                     err_illegal, drop_count, ov);
        end
    endtask

    task automatic test_reset_busy();
        ordy     = 3'b000;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sel     = k[1:0];
            in_data = 32'h5000_0000 + k;
            step();
        end
        sel     = 2'd0;
        in_data = 32'h7777_7777;
        reset   = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        compared++;
        if (ov !== 3'b000 || out1_data !== 32'h0 || out2_data !== 32'h0 || out3_data !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_busy_lanes: got v=%b d=%h/%h/%h expected v=000 d=0",
                     ov, out1_data, out2_data, out3_data);
        end
        compared++;
        if (err_illegal !== 1'b0 || drop_count !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_busy_err: got %b/%0d expected 0/0", err_illegal, drop_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            sel      = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            in_data  = $urandom;
            ordy     = 3'($urandom_range(0, 7));
            step();
        end
        in_valid = 1'b0;
        ordy     = 3'b111;
        step();
        step();
        compared++;
        if (ov !== 3'b000) begin
            mismatched++;
            $display("FAIL random_drain: got v=%b expected 000", ov);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        sb_on      = 1'b0;
        mv         = 3'b000;
        merr       = 1'b0;
        mdrop      = 8'd0;
        for (int k = 0; k < 3; k++) mdata[k] = 32'h0000_0000;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'h0;
        sel      = 2'd0;
        ordy     = 3'b000;
        @(posedge clk);
        #1;
        test_reset();
        test_single_route();
        test_full_replace();
        test_back_to_back();
        test_illegal();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
